night_cycle_ctrl: RTL and testbench

NIGHT_CYCLE_CTRL -- requirements
Module: night_cycle_ctrl

---
 rtl/night_cycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_night_cycle_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/night_cycle_ctrl.sv
// night_cycle_ctrl
//
// Day/night cycle sequencer for the game palette. The cycle runs
// DAY -> TO_NIGHT -> NIGHT -> TO_DAY -> DAY. During each transition isnight
// blinks so the palette flickers between the two looks before it settles.
// Time advances only on counted ticks, which are frame_tick pulses that
// arrive while run is high. Every output is registered, so it changes on the
// clock edge that ends the counted-tick cycle.
//
// Parameters
//   DAY_FRAMES    counted ticks spent in DAY
//   NIGHT_FRAMES  counted ticks spent in NIGHT
//   BLINK_PERIOD  counted ticks between isnight toggles during a transition
//   BLINK_TOGGLES toggles per transition (even, >= 2)
//
// Ports
//   Clk           in   system clock, rising edge
//   Reset_n       in   asynchronous active-low reset
//   frame_tick    in   one-cycle pulse per video frame
//   run           in   game running; gates frame counting
//   restart       in   synchronous pulse; returns the cycle to a fresh DAY
//   isnight       out  palette day/night select
//   phase         out  00 DAY, 01 TO_NIGHT, 10 NIGHT, 11 TO_DAY
//   in_transition out  high while phase is TO_NIGHT or TO_DAY
//   night_count   out  completed nights, saturating at 255

module night_cycle_ctrl #(
    parameter int DAY_FRAMES    = 1800,
    parameter int NIGHT_FRAMES  = 600,
    parameter int BLINK_PERIOD  = 4,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       run,
    input  logic       restart,
    output logic       isnight,
    output logic [1:0] phase,
    output logic       in_transition,
    output logic [7:0] night_count
);

    // Parameter sanity: a zero length phase or an odd toggle count would
    // leave the palette in the wrong look at the end of a transition.
    if (DAY_FRAMES < 1 || NIGHT_FRAMES < 1 || BLINK_PERIOD < 1 ||
        BLINK_TOGGLES < 2 || (BLINK_TOGGLES % 2) != 0) begin : g_bad_params
        $error("night_cycle_ctrl: illegal parameter set");
    end

    // The frame counter covers the longer of DAY/NIGHT so it never wraps
    // inside a phase; it only ever reaches LENGTH-1 before being cleared.
    localparam int FRAME_MAX = (DAY_FRAMES > NIGHT_FRAMES) ? DAY_FRAMES : NIGHT_FRAMES;
    localparam int FW        = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;
    localparam int BW        = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam int TW        = $clog2(BLINK_TOGGLES);

    localparam logic [FW-1:0] DAY_LAST    = FW'(DAY_FRAMES - 1);
    localparam logic [FW-1:0] NIGHT_LAST  = FW'(NIGHT_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_PERIOD - 1);
    localparam logic [TW-1:0] TOGGLE_LAST = TW'(BLINK_TOGGLES - 1);

    typedef enum logic [1:0] {
        PH_DAY      = 2'b00,
        PH_TO_NIGHT = 2'b01,
        PH_NIGHT    = 2'b10,
        PH_TO_DAY   = 2'b11
    } phase_t;

    phase_t          phase_reg,       phase_next;
    logic            isnight_reg,     isnight_next;
    logic [7:0]      night_count_reg, night_count_next;
    logic [FW-1:0]   frame_cnt_reg,   frame_cnt_next;
    logic [BW-1:0]   blink_cnt_reg,   blink_cnt_next;
    logic [TW-1:0]   toggle_cnt_reg,  toggle_cnt_next;

    logic counted_tick;
    assign counted_tick = frame_tick & run;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase_reg       <= PH_DAY;
            isnight_reg     <= 1'b0;
            night_count_reg <= 8'd0;
            frame_cnt_reg   <= '0;
            blink_cnt_reg   <= '0;
            toggle_cnt_reg  <= '0;
        end else begin
            phase_reg       <= phase_next;
            isnight_reg     <= isnight_next;
            night_count_reg <= night_count_next;
            frame_cnt_reg   <= frame_cnt_next;
            blink_cnt_reg   <= blink_cnt_next;
            toggle_cnt_reg  <= toggle_cnt_next;
        end
    end

    always_comb begin
        phase_next       = phase_reg;
        isnight_next     = isnight_reg;
        night_count_next = night_count_reg;
        frame_cnt_next   = frame_cnt_reg;
        blink_cnt_next   = blink_cnt_reg;
        toggle_cnt_next  = toggle_cnt_reg;

        if (restart) begin
            // Restart wins over a coincident tick and ignores run.
            phase_next       = PH_DAY;
            isnight_next     = 1'b0;
            night_count_next = 8'd0;
            frame_cnt_next   = '0;
            blink_cnt_next   = '0;
            toggle_cnt_next  = '0;
        end else if (counted_tick) begin
            case (phase_reg)
                PH_DAY: begin
                    if (frame_cnt_reg == DAY_LAST) begin
                        phase_next      = PH_TO_NIGHT;
                        isnight_next    = 1'b1;
                        frame_cnt_next  = '0;
                        blink_cnt_next  = '0;
                        toggle_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + FW'(1);
                    end
                end
                PH_NIGHT: begin
                    if (frame_cnt_reg == NIGHT_LAST) begin
                        phase_next      = PH_TO_DAY;
                        isnight_next    = 1'b0;
                        frame_cnt_next  = '0;
                        blink_cnt_next  = '0;
                        toggle_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + FW'(1);
                    end
                end
                default: begin
                    // Both transitions share the blink logic. The toggle
                    // count is even, so the final toggle lands isnight back
                    // on its starting value, which is the destination look.
                    if (blink_cnt_reg == BLINK_LAST) begin
                        blink_cnt_next = '0;
                        isnight_next   = ~isnight_reg;
                        if (toggle_cnt_reg == TOGGLE_LAST) begin
                            toggle_cnt_next = '0;
                            frame_cnt_next  = '0;
                            if (phase_reg == PH_TO_NIGHT) begin
                                phase_next   = PH_NIGHT;
                                isnight_next = 1'b1;
                                if (night_count_reg != 8'hFF) begin
                                    night_count_next = night_count_reg + 8'd1;
                                end
                            end else begin
                                phase_next   = PH_DAY;
                                isnight_next = 1'b0;
                            end
                        end else begin
                            toggle_cnt_next = toggle_cnt_reg + TW'(1);
                        end
                    end else begin
                        blink_cnt_next = blink_cnt_reg + BW'(1);
                    end
                end
            endcase
        end
    end

    assign isnight       = isnight_reg;
    assign phase         = phase_reg;
    // TO_NIGHT (01) and TO_DAY (11) are exactly the encodings with bit 0 set.
    assign in_transition = phase_reg[0];
    assign night_count   = night_count_reg;

endmodule

// File: tb/tb_night_cycle_ctrl.sv
module tb_night_cycle_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_tick;
    logic       run;
    logic       restart;
    logic       isnight;
    logic [1:0] phase;
    logic       in_transition;
    logic [7:0] night_count;

    int total = 0;
    int bad   = 0;

    night_cycle_ctrl #(
        .DAY_FRAMES   (4),
        .NIGHT_FRAMES (3),
        .BLINK_PERIOD (2),
        .BLINK_TOGGLES(2)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .run          (run),
        .restart      (restart),
        .isnight      (isnight),
        .phase        (phase),
        .in_transition(in_transition),
        .night_count  (night_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] ph;
        logic       isn;
        logic [7:0] nc;
        bit         chk_nc;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;

    // Expected phase/isnight after each counted tick of one full cycle
    // (4 DAY, 4 TO_NIGHT, 3 NIGHT, 4 TO_DAY).
    logic [1:0] tab_ph [15];
    logic       tab_in [15];
    int pos;
    int nights;

    task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Push the next entry of the cycle table; night count is tracked from
    // the TO_NIGHT -> NIGHT entry and only checked outside NIGHT.
    task automatic push_cycle();
        exp_t e;
        if (pos == 7 && nights < 255) nights++;
        e.ph     = tab_ph[pos];
        e.isn    = tab_in[pos];
        e.nc     = 8'(nights);
        e.chk_nc = (tab_ph[pos] != 2'b10);
        exp_q.push_back(e);
        last_e = e;
        pos = (pos + 1) % 15;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            cmp({tag, "_queue_empty"}, 8'd1, 8'd0);
            return;
        end
        e = exp_q.pop_front();
        cmp({tag, "_phase"}, {6'd0, phase}, {6'd0, e.ph});
        cmp({tag, "_isnight"}, {7'd0, isnight}, {7'd0, e.isn});
        cmp({tag, "_in_trans"}, {7'd0, in_transition}, {7'd0, e.ph[0]});
        if (e.chk_nc) cmp({tag, "_night_count"}, night_count, e.nc);
        $display("tick %-10s phase=%b isnight=%b in_trans=%b night_count=%0d",
                 tag, phase, isnight, in_transition, night_count);
    endtask

    // Drive one frame_tick cycle, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic rs);
        frame_tick = 1'b1;
        run        = r;
        restart    = rs;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
        restart    = 1'b0;
        run        = 1'b1;
    endtask

    task automatic run_ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            push_cycle();
            step(1'b1, 1'b0);
            pop_check(tag);
        end
    endtask

    task automatic restart_model();
        exp_t e;
        e.ph = 2'b00; e.isn = 1'b0; e.nc = 8'd0; e.chk_nc = 1'b1;
        exp_q.push_back(e);
        last_e = e;
        pos    = 0;
        nights = 0;
    endtask

    initial begin
        tab_ph = '{2'b00, 2'b00, 2'b00, 2'b01,
                   2'b01, 2'b01, 2'b01, 2'b10,
                   2'b10, 2'b10, 2'b11,
                   2'b11, 2'b11, 2'b11, 2'b00};
        tab_in = '{1'b0, 1'b0, 1'b0, 1'b1,
                   1'b1, 1'b0, 1'b0, 1'b1,
                   1'b1, 1'b1, 1'b0,
                   1'b0, 1'b1, 1'b1, 1'b0};
        pos = 0; nights = 0;
        frame_tick = 1'b0; run = 1'b1; restart = 1'b0;
        Reset_n = 1'b0;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        cmp("reset_phase", {6'd0, phase}, 8'd0);
        cmp("reset_isnight", {7'd0, isnight}, 8'd0);
        cmp("reset_in_trans", {7'd0, in_transition}, 8'd0);
        cmp("reset_night_count", night_count, 8'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // DAY plus first TO_NIGHT tick, then a 20-pulse pause
        run_ticks(5, "first");
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(last_e);
            step(1'b0, 1'b0);
            pop_check("paused");
        end
        // Rest of the first cycle
        run_ticks(10, "first");

        // Second night, then restart coincident with a counted NIGHT tick
        run_ticks(9, "to_night2");
        restart_model();
        step(1'b1, 1'b1);
        pop_check("restart");
        run_ticks(4, "after_rst");

        // Restart with run low mid-transition
        run_ticks(1, "pre_rst2");
        restart_model();
        step(1'b0, 1'b1);
        pop_check("restart_norun");

        // Asynchronous reset between edges while TO_NIGHT shows isnight=0
        run_ticks(6, "pre_areset");
        cmp("pre_areset_isnight", {7'd0, isnight}, 8'd0);
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        cmp("areset_phase", {6'd0, phase}, 8'd0);
        cmp("areset_isnight", {7'd0, isnight}, 8'd0);
        cmp("areset_in_trans", {7'd0, in_transition}, 8'd0);
        cmp("areset_night_count", night_count, 8'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        pos = 0; nights = 0;
        @(posedge Clk);
        #1;
        run_ticks(4, "post_areset");

        // Long run for night_count saturation
        run_ticks(11, "finish_cyc");
        for (int c = 0; c < 260; c++) begin
            run_ticks(15, "long");
        end
        cmp("saturated_night_count", night_count, 8'd255);
        cmp("saturated_phase", {6'd0, phase}, 8'd0);
        cmp("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
